// File: rtl/inst_buffer_pkg.sv
// Local types and helpers for the instruction buffer.
package inst_buffer_pkg;

    localparam int IB_SLOTS = 3;

    typedef logic [1:0] slot_cnt_t;

    function automatic slot_cnt_t min_slot(
        input slot_cnt_t a,
        input slot_cnt_t b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sys_defs.sv
// Shared pipeline definitions: fetch/decode packet and buffer depth.
`ifndef IB_DEPTH
`define IB_DEPTH 8
`endif

package sys_defs;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] npc;
        logic [31:0] pc;
    } IF_ID_PACKET;

endpackage

// File: rtl/ib_compact.sv
// Packs the valid slots of a 3-wide bundle toward slot 2, keeping order.
module ib_compact
    import sys_defs::*;
    import inst_buffer_pkg::*;
(
    input  IF_ID_PACKET [2:0] pkt_in,
    output IF_ID_PACKET [2:0] pkt_out,
    output slot_cnt_t         num
);

    slot_cnt_t n;

    always_comb begin
        pkt_out = '0;
        n       = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (pkt_in[k].valid) begin
                pkt_out[2'd2 - n] = pkt_in[k];
                n = n + 2'd1;
            end
        end
        num = n;
    end

endmodule

// File: rtl/inst_buffer.sv
// Three-wide circular instruction queue between fetch and dispatch.
module inst_buffer
    import sys_defs::*;
    import inst_buffer_pkg::*;
#(
    parameter int IB_DEPTH = `IB_DEPTH,
    parameter int IB_PTR_W = $clog2(IB_DEPTH),
    parameter int IB_CNT_W = $clog2(IB_DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  IF_ID_PACKET [2:0]   if_packet_in,
    input  logic                squash,
    input  logic [1:0]          dis_num,
    output IF_ID_PACKET [2:0]   ib_packet_out,
    output logic [IB_CNT_W-1:0] ib_space,
    output logic [1:0]          ib_accept_num
);

    IF_ID_PACKET         mem [IB_DEPTH];
    logic [IB_PTR_W-1:0] head;
    logic [IB_PTR_W-1:0] tail;
    logic [IB_CNT_W-1:0] count;

    IF_ID_PACKET [2:0]   packed_in;
    slot_cnt_t           in_num;
    slot_cnt_t           accepted;
    slot_cnt_t           out_num;
    slot_cnt_t           deq;

    localparam logic [IB_PTR_W-1:0] OFF1 = IB_PTR_W'(1);
    localparam logic [IB_PTR_W-1:0] OFF2 = IB_PTR_W'(2);

    ib_compact u_compact (
        .pkt_in  (if_packet_in),
        .pkt_out (packed_in),
        .num     (in_num)
    );

    assign ib_space = IB_CNT_W'(IB_DEPTH) - count;
    assign out_num  = (count >= IB_CNT_W'(IB_SLOTS)) ? 2'd3 : count[1:0];
    assign deq      = squash ? 2'd0 : min_slot(dis_num, out_num);

    // Space is judged before this cycle's dequeue, so a full buffer
    // refuses input even while dispatch drains it.
    always_comb begin
        accepted = 2'd0;
        if (reset && !squash) begin
            if (IB_CNT_W'(in_num) > ib_space)
                accepted = ib_space[1:0];
            else
                accepted = in_num;
        end
    end

    assign ib_accept_num = accepted;

    always_comb begin
        ib_packet_out = '0;
        if (out_num > 2'd0)
            ib_packet_out[2] = mem[head];
        if (out_num > 2'd1)
            ib_packet_out[1] = mem[head + OFF1];
        if (out_num > 2'd2)
            ib_packet_out[0] = mem[head + OFF2];
    end

    always_ff @(posedge clock) begin
        if (accepted > 2'd0)
            mem[tail] <= packed_in[2];
        if (accepted > 2'd1)
            mem[tail + OFF1] <= packed_in[1];
        if (accepted > 2'd2)
            mem[tail + OFF2] <= packed_in[0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + IB_PTR_W'(deq);
            tail  <= tail + IB_PTR_W'(accepted);
            count <= count + IB_CNT_W'(accepted) - IB_CNT_W'(deq);
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Table-driven bench for inst_buffer with a PC scoreboard queue.
module tb_inst_buffer;
    import sys_defs::*;

    typedef struct {
        string       nm;
        logic [2:0]  mask;
        logic [31:0] pc0;
        logic [1:0]  dis;
        logic        sq;
        logic [1:0]  acc;
        logic [3:0]  space;
    } vec_t;

    logic              clock;
    logic              reset;
    IF_ID_PACKET [2:0] if_packet_in;
    logic              squash;
    logic [1:0]        dis_num;
    IF_ID_PACKET [2:0] ib_packet_out;
    logic [3:0]        ib_space;
    logic [1:0]        ib_accept_num;

    int          n_vec;
    int          n_err;
    logic [31:0] sb [$];
    vec_t        tbl [$];

    inst_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .if_packet_in  (if_packet_in),
        .squash        (squash),
        .dis_num       (dis_num),
        .ib_packet_out (ib_packet_out),
        .ib_space      (ib_space),
        .ib_accept_num (ib_accept_num)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string nm);
        for (int k = 0; k < 3; k++) begin
            if (k < sb.size()) begin
                chk($sformatf("%s out%0d valid", nm, 2 - k),
                    32'(ib_packet_out[2-k].valid), 32'd1);
                chk($sformatf("%s out%0d pc", nm, 2 - k),
                    ib_packet_out[2-k].pc, sb[k]);
            end else begin
                chk($sformatf("%s out%0d valid", nm, 2 - k),
                    32'(ib_packet_out[2-k].valid), 32'd0);
                chk($sformatf("%s out%0d pc", nm, 2 - k),
                    ib_packet_out[2-k].pc, 32'd0);
            end
        end
    endtask

    task automatic drive(input logic [2:0] mask, input logic [31:0] pc0);
        for (int s = 0; s < 3; s++) begin
            if_packet_in[s]       = '0;
            if_packet_in[s].valid = mask[s];
            if_packet_in[s].pc    = pc0 + 32'(4 * (2 - s));
            if_packet_in[s].npc   = pc0 + 32'(4 * (3 - s));
            if_packet_in[s].inst  = if_packet_in[s].pc ^ 32'h1300_0013;
        end
    endtask

    task automatic step(input vec_t v);
        int deq;
        int pushed;
        @(negedge clock);
        drive(v.mask, v.pc0);
        squash  = v.sq;
        dis_num = v.dis;
        #1;
        check_outputs(v.nm);
        chk({v.nm, " accept"}, 32'(ib_accept_num), 32'(v.acc));
        if (v.sq) begin
            sb.delete();
        end else begin
            deq = int'(v.dis);
            if (deq > sb.size()) deq = sb.size();
            if (deq > 3) deq = 3;
            repeat (deq) void'(sb.pop_front());
            pushed = 0;
            for (int s = 2; s >= 0; s--) begin
                if (v.mask[s] && pushed < int'(v.acc)) begin
                    sb.push_back(v.pc0 + 32'(4 * (2 - s)));
                    pushed++;
                end
            end
        end
        @(posedge clock);
        #1;
        chk({v.nm, " space"}, 32'(ib_space), 32'(v.space));
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, " space"}, 32'(ib_space), 32'd8);
        chk({nm, " accept"}, 32'(ib_accept_num), 32'd0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s out%0d valid", nm, k),
                32'(ib_packet_out[k].valid), 32'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        squash  = 1'b0;
        dis_num = 2'd0;
        drive(3'b111, 32'h0);

        tbl.push_back(vec_t'{"rst_first", 3'b111, 32'h000, 2'd0, 1'b0, 2'd3, 4'd5});
        tbl.push_back(vec_t'{"drain_a",   3'b000, 32'h000, 2'd3, 1'b0, 2'd0, 4'd8});
        tbl.push_back(vec_t'{"compact",   3'b101, 32'h010, 2'd0, 1'b0, 2'd2, 4'd6});
        tbl.push_back(vec_t'{"drain_b",   3'b000, 32'h000, 2'd3, 1'b0, 2'd0, 4'd8});
        tbl.push_back(vec_t'{"fill1",     3'b111, 32'h100, 2'd0, 1'b0, 2'd3, 4'd5});
        tbl.push_back(vec_t'{"fill2",     3'b111, 32'h10c, 2'd0, 1'b0, 2'd3, 4'd2});
        tbl.push_back(vec_t'{"fill3",     3'b111, 32'h118, 2'd0, 1'b0, 2'd2, 4'd0});
        tbl.push_back(vec_t'{"full_deq",  3'b111, 32'h200, 2'd3, 1'b0, 2'd0, 4'd3});
        tbl.push_back(vec_t'{"drain_c",   3'b000, 32'h000, 2'd3, 1'b0, 2'd0, 4'd6});
        tbl.push_back(vec_t'{"drain_d",   3'b000, 32'h000, 2'd3, 1'b0, 2'd0, 4'd8});
        tbl.push_back(vec_t'{"align",     3'b100, 32'h030, 2'd0, 1'b0, 2'd1, 4'd7});
        tbl.push_back(vec_t'{"align_deq", 3'b000, 32'h000, 2'd3, 1'b0, 2'd0, 4'd8});
        tbl.push_back(vec_t'{"wrap_enq",  3'b111, 32'h040, 2'd0, 1'b0, 2'd3, 4'd5});
        tbl.push_back(vec_t'{"wrap_deq",  3'b000, 32'h000, 2'd3, 1'b0, 2'd0, 4'd8});
        tbl.push_back(vec_t'{"sim_pre1",  3'b111, 32'h050, 2'd0, 1'b0, 2'd3, 4'd5});
        tbl.push_back(vec_t'{"sim_pre2",  3'b110, 32'h060, 2'd0, 1'b0, 2'd2, 4'd3});
        tbl.push_back(vec_t'{"simult",    3'b111, 32'h070, 2'd2, 1'b0, 2'd3, 4'd2});
        tbl.push_back(vec_t'{"squash",    3'b111, 32'h080, 2'd3, 1'b1, 2'd0, 4'd8});
        tbl.push_back(vec_t'{"empty_dis", 3'b000, 32'h000, 2'd3, 1'b0, 2'd0, 4'd8});
        tbl.push_back(vec_t'{"post_sq",   3'b111, 32'h090, 2'd0, 1'b0, 2'd3, 4'd5});

        repeat (2) begin
            @(posedge clock);
            #1;
            check_cleared("in_reset");
        end
        reset = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // Reset in the middle of operation with entries buffered.
        @(negedge clock);
        drive(3'b111, 32'h0c0);
        dis_num = 2'd0;
        squash  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_cleared("mid_reset");
        sb.delete();
        @(posedge clock);
        #1;
        check_cleared("mid_reset_hold");
        drive(3'b000, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        step(vec_t'{"after_rst", 3'b111, 32'h0a0, 2'd0, 1'b0, 2'd3, 4'd5});
        step(vec_t'{"final_deq", 3'b000, 32'h000, 2'd3, 1'b0, 2'd0, 4'd8});
        @(negedge clock);
        #1;
        check_outputs("final_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Three-wide instruction queue between `pipeline_fetch` and dispatch. Each cycle it accepts up to three `IF_ID_PACKET`s from fetch and presents up to three of the oldest buffered packets to dispatch. It reports free space back to fetch for stalling, and flushes completely on a branch squash.

## Interface
Parameters:
- `IB_DEPTH`, 8: number of entries; must be a power of two and at least 4.
- `IB_PTR_W`, `$clog2(IB_DEPTH)`: width of the head and tail pointers.
- `IB_CNT_W`, `$clog2(IB_DEPTH+1)`: width of the occupancy count.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. Clears all state immediately while low.
- `if_packet_in`  in  `IF_ID_PACKET[2:0]`  fetch bundle; slot 2 is program-order oldest.
- `squash`  in  1  branch mispredict or redirect; flushes the buffer.
- `dis_num`  in  2  number of output packets dispatch consumes this cycle (0–3).
- `ib_packet_out`  out  `IF_ID_PACKET[2:0]`  oldest entries; slot 2 is the head.
- `ib_space`  out  `IB_CNT_W`  free entries: `IB_DEPTH - count`.
- `ib_accept_num`  out  2  number of input packets enqueued this cycle.

## Operation
Storage and pointers:
- Circular array of `IB_DEPTH` packets, with `head`, `tail` and `count` registers.
- Pointers wrap modulo `IB_DEPTH` through natural overflow of `IB_PTR_W` bits.

Enqueue:
- Valid input slots are scanned in the order 2, 1, 0. Invalid slots are skipped (compacted), so a hole in the bundle never becomes a buffered entry.
- Accepted count = min(number of valid inputs, `ib_space`), where `ib_space` is based on the pre-dequeue `count`.
- Excess valid inputs are dropped. Fetch must present no more valid packets than `ib_space`; `ib_accept_num` reports what was actually taken.
- Accepted packets are written at `tail`, `tail+1`, `tail+2` in oldest-first order.

Output:
- `ib_packet_out[2-k]` = entry at `head+k` for k < min(count, 3).
- Remaining output slots are driven with all fields 0 (`valid` = 0).
- Outputs are a combinational read of registered state; input signals never reach them in the same cycle.

Dequeue:
- Effective dequeue = min(`dis_num`, min(count, 3)), i.e. clamped to the number of valid output slots.
- `head` advances by the effective dequeue.

Register update on each edge:
- `count <= count + accepted - dequeued`.
- `tail` advances by `accepted`.
- Enqueue and dequeue in the same cycle are legal at any occupancy, including full.

Squash:
- Takes priority over enqueue and dequeue in the same cycle.
- At the next edge, `head`, `tail` and `count` all go to 0. Inputs present in the squash cycle are discarded and `ib_accept_num` is 0.

Reset (`reset` = 0):
- Asynchronous, with the same clearing effect as squash.
- Output values while reset is low: `ib_packet_out` all valid = 0, `ib_space` = `IB_DEPTH`, `ib_accept_num` = 0.
- Reset asserted mid-operation loses all entries. The first enqueue is at the first rising edge after deassertion.

## Timing
- Enqueue-to-visible latency is 1 cycle: a packet accepted at edge N appears on `ib_packet_out` after edge N.
- `ib_space` and `ib_packet_out` depend only on registered state.
- `ib_accept_num` is combinational from `if_packet_in`, `count` and `squash`.
- The full→empty round trip needs at least `IB_DEPTH`/3 dispatch cycles.
- Boundary behaviour:
  - Full: `ib_space` = 0, so all inputs are dropped, even when dispatch drains in the same cycle.
  - Empty: all outputs invalid, and `dis_num` is ignored.
  - Wrap-around: an enqueue straddling index `IB_DEPTH-1` → 0 keeps program order.

## Structure
- `IF_ID_PACKET` comes from the existing shared package `sys_defs`.
- Add `` `IB_DEPTH `` to `sys_defs` so that fetch and dispatch can size their stall logic.
- One natural sub-module, `ib_compact`: combinational 3-slot valid compaction that produces packed packets plus a count. It is reusable by dispatch.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles while driving 3 valid inputs → `ib_space` = 8, all outputs invalid. Release → next edge accepts 3, and `ib_packet_out` shows PC 0, 4, 8 in slots 2, 1, 0.
- **Compaction:** inputs with slot 2 and slot 0 valid (PC 0x10, 0x18) and slot 1 invalid → `ib_accept_num` = 2; next cycle slot 2 = 0x10, slot 1 = 0x18, slot 0 invalid.
- **Fill:** 3, 3, 3 valid inputs with `dis_num` = 0 → `ib_accept_num` = 3, 3, 2; then `ib_space` = 0, and a further 3 inputs give accept 0.
- **Wrap-around:** from head = tail = 6 with count 0, enqueue 3 (PC 0x40, 0x44, 0x48) → entries at indices 6, 7, 0; output order preserved; `dis_num` = 3 → empty with head = 1.
- **Simultaneous:** count 5, 3 inputs, `dis_num` = 2 → accept 3, count becomes 6.
- **Squash:** count 6 with `squash` = 1, 3 valid inputs and `dis_num` = 3 → `ib_accept_num` = 0; next cycle count 0, all outputs invalid, `ib_space` = 8.
